// File: rtl/pulse_generator.sv
// rtl/pulse_generator.sv - periodic tachometer pulse synthesiser with boundary-aligned period reload
module pulse_generator #(
    parameter int RPM_WIDTH   = 32,
    parameter int HIGH_CYCLES = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [RPM_WIDTH-1:0]   period_in,
    input  logic                   period_load,
    output logic                   pulse,
    output logic [RPM_WIDTH-1:0]   period_cur,
    output logic [COUNT_WIDTH-1:0] pulse_count,
    output logic                   running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [RPM_WIDTH-1:0] HIGH_LEN_MAX = RPM_WIDTH'(HIGH_CYCLES);
    localparam logic [RPM_WIDTH-1:0] ONE          = RPM_WIDTH'(1);

    state_t                 state;
    state_t                 state_next;
    logic [RPM_WIDTH-1:0]   pending;
    logic [RPM_WIDTH-1:0]   cnt;
    logic [RPM_WIDTH-1:0]   cnt_next;
    logic [RPM_WIDTH-1:0]   period_next;
    logic [RPM_WIDTH-1:0]   eff_period;
    logic [RPM_WIDTH-1:0]   high_len;
    logic                   start_ok;
    logic                   enter_high;

    // A load in the boundary cycle bypasses the pending register so it applies immediately
    assign eff_period = period_load ? period_in : pending;
    assign start_ok   = enable && (eff_period != '0);
    // Clamping high time to N keeps at least one low cycle in every period
    assign high_len   = (period_cur < HIGH_LEN_MAX) ? period_cur : HIGH_LEN_MAX;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt + ONE;
        period_next = period_cur;
        enter_high  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (start_ok) begin
                    state_next  = HIGH;
                    period_next = eff_period;
                    enter_high  = 1'b1;
                end
            end
            HIGH: begin
                if (cnt == high_len - ONE) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                // cnt never exceeds period_cur, so the boundary compare needs no N+1 term
                if (cnt == period_cur) begin
                    cnt_next = '0;
                    if (start_ok) begin
                        state_next  = HIGH;
                        period_next = eff_period;
                        enter_high  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            pending     <= '0;
            period_cur  <= '0;
            pulse_count <= '0;
            pulse       <= 1'b0;
            running     <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            period_cur  <= period_next;
            pulse       <= (state_next == HIGH);
            running     <= (state_next != IDLE);
            if (period_load) begin
                pending <= period_in;
            end
            if (enter_high) begin
                pulse_count <= pulse_count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pulse_generator.sv
// tb/tb_pulse_generator.sv - directed self-checking bench for pulse_generator
module tb_pulse_generator;

    localparam int RPM_WIDTH   = 32;
    localparam int COUNT_WIDTH = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic [RPM_WIDTH-1:0]   period_in;
    logic                   period_load;
    logic                   pulse;
    logic [RPM_WIDTH-1:0]   period_cur;
    logic [COUNT_WIDTH-1:0] pulse_count;
    logic                   running;

    int                     n_checks = 0;
    int                     n_fail   = 0;
    logic [COUNT_WIDTH-1:0] exp_cnt  = '0;

    pulse_generator #(
        .RPM_WIDTH  (RPM_WIDTH),
        .HIGH_CYCLES(4),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period_in  (period_in),
        .period_load(period_load),
        .pulse      (pulse),
        .period_cur (period_cur),
        .pulse_count(pulse_count),
        .running    (running)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; period_in = '0; period_load = 1'b0;
        tick(); tick();
        n_checks += 4;
        if (pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %0d expected 0", pulse); end
        if (period_cur !== '0) begin n_fail++; $display("FAIL reset_period_cur: got %0d expected 0", period_cur); end
        if (pulse_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", pulse_count); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %0d expected 0", running); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        period_in = 9; period_load = 1'b1;
        tick();
        period_load = 1'b0;
        n_checks += 2;
        if (pulse !== 1'b0) begin n_fail++; $display("FAIL basic_idle_pulse: got %0d expected 0", pulse); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL basic_idle_running: got %0d expected 0", running); end
        enable = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            if (i % 10 == 0) exp_cnt++;
            n_checks += 4;
            if (pulse !== (i % 10 < 4)) begin n_fail++; $display("FAIL basic_pulse[%0d]: got %0d expected %0d", i, pulse, (i % 10 < 4)); end
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, pulse_count, exp_cnt); end
            if (period_cur !== 32'd9) begin n_fail++; $display("FAIL basic_period_cur[%0d]: got %0d expected 9", i, period_cur); end
            if (running !== 1'b1) begin n_fail++; $display("FAIL basic_running[%0d]: got %0d expected 1", i, running); end
            tick();
        end
    endtask

    task automatic test_period_change();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) exp_cnt++;
            if (i == 4) period_load = 1'b0;
            n_checks += 3;
            if (pulse !== (i < 4)) begin n_fail++; $display("FAIL chg_old_pulse[%0d]: got %0d expected %0d", i, pulse, (i < 4)); end
            if (period_cur !== 32'd9) begin n_fail++; $display("FAIL chg_old_period[%0d]: got %0d expected 9", i, period_cur); end
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL chg_old_count[%0d]: got %0d expected %0d", i, pulse_count, exp_cnt); end
            if (i == 3) begin period_in = 4; period_load = 1'b1; end
            tick();
        end
        for (int j = 0; j < 15; j++) begin
            if (j % 5 == 0) exp_cnt++;
            n_checks += 3;
            if (pulse !== (j % 5 < 4)) begin n_fail++; $display("FAIL chg_new_pulse[%0d]: got %0d expected %0d", j, pulse, (j % 5 < 4)); end
            if (period_cur !== 32'd4) begin n_fail++; $display("FAIL chg_new_period[%0d]: got %0d expected 4", j, period_cur); end
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL chg_new_count[%0d]: got %0d expected %0d", j, pulse_count, exp_cnt); end
            tick();
        end
    endtask

    task automatic test_bypass_clamp();
        for (int k = 0; k < 5; k++) begin
            if (k == 0) exp_cnt++;
            n_checks += 2;
            if (pulse !== (k < 4)) begin n_fail++; $display("FAIL byp_old_pulse[%0d]: got %0d expected %0d", k, pulse, (k < 4)); end
            if (period_cur !== 32'd4) begin n_fail++; $display("FAIL byp_old_period[%0d]: got %0d expected 4", k, period_cur); end
            if (k == 4) begin period_in = 2; period_load = 1'b1; end
            tick();
        end
        period_load = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k % 3 == 0) exp_cnt++;
            n_checks += 3;
            if (pulse !== (k % 3 < 2)) begin n_fail++; $display("FAIL byp_new_pulse[%0d]: got %0d expected %0d", k, pulse, (k % 3 < 2)); end
            if (period_cur !== 32'd2) begin n_fail++; $display("FAIL byp_new_period[%0d]: got %0d expected 2", k, period_cur); end
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL byp_new_count[%0d]: got %0d expected %0d", k, pulse_count, exp_cnt); end
            tick();
        end
    endtask

    task automatic test_stop_and_zero();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) exp_cnt++;
            if (k == 2) begin period_in = 9; period_load = 1'b1; end
            tick();
        end
        period_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) exp_cnt++;
            n_checks += 3;
            if (pulse !== (i < 4)) begin n_fail++; $display("FAIL stop_pulse[%0d]: got %0d expected %0d", i, pulse, (i < 4)); end
            if (running !== 1'b1) begin n_fail++; $display("FAIL stop_running[%0d]: got %0d expected 1", i, running); end
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL stop_count[%0d]: got %0d expected %0d", i, pulse_count, exp_cnt); end
            if (i == 1) enable = 1'b0;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            n_checks += 4;
            if (pulse !== 1'b0) begin n_fail++; $display("FAIL stopped_pulse[%0d]: got %0d expected 0", i, pulse); end
            if (running !== 1'b0) begin n_fail++; $display("FAIL stopped_running[%0d]: got %0d expected 0", i, running); end
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL stopped_count[%0d]: got %0d expected %0d", i, pulse_count, exp_cnt); end
            if (period_cur !== 32'd9) begin n_fail++; $display("FAIL stopped_period[%0d]: got %0d expected 9", i, period_cur); end
            tick();
        end
        period_in = 0; period_load = 1'b1;
        tick();
        period_load = 1'b0; enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks += 3;
            if (pulse !== 1'b0) begin n_fail++; $display("FAIL zero_pulse[%0d]: got %0d expected 0", i, pulse); end
            if (running !== 1'b0) begin n_fail++; $display("FAIL zero_running[%0d]: got %0d expected 0", i, running); end
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL zero_count[%0d]: got %0d expected %0d", i, pulse_count, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid_pulse();
        period_in = 9; period_load = 1'b1;
        tick();
        period_load = 1'b0;
        exp_cnt++;
        n_checks += 2;
        if (pulse !== 1'b1) begin n_fail++; $display("FAIL rmid_start_pulse: got %0d expected 1", pulse); end
        if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL rmid_start_count: got %0d expected %0d", pulse_count, exp_cnt); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        n_checks += 4;
        if (pulse !== 1'b0) begin n_fail++; $display("FAIL rmid_pulse: got %0d expected 0", pulse); end
        if (pulse_count !== '0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", pulse_count); end
        if (period_cur !== '0) begin n_fail++; $display("FAIL rmid_period: got %0d expected 0", period_cur); end
        if (running !== 1'b0) begin n_fail++; $display("FAIL rmid_running: got %0d expected 0", running); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks += 2;
            if (pulse !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_pulse[%0d]: got %0d expected 0", i, pulse); end
            if (running !== 1'b0) begin n_fail++; $display("FAIL rmid_idle_running[%0d]: got %0d expected 0", i, running); end
        end
    endtask

    task automatic test_count_wrap();
        period_in = 2; period_load = 1'b1;
        tick();
        period_load = 1'b0;
        for (int k = 0; k < 51; k++) begin
            if (k % 3 == 0) exp_cnt++;
            n_checks += 2;
            if (pulse_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", k, pulse_count, exp_cnt); end
            if (pulse !== (k % 3 < 2)) begin n_fail++; $display("FAIL wrap_pulse[%0d]: got %0d expected %0d", k, pulse, (k % 3 < 2)); end
            tick();
        end
        n_checks++;
        if (pulse_count !== 4'd2) begin n_fail++; $display("FAIL wrap_final: got %0d expected 2", pulse_count); end
        enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period_change();
        test_bypass_clamp();
        test_stop_and_zero();
        test_reset_mid_pulse();
        test_count_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
Tachometer-signal synthesiser for the rpm-counter design. It converts a programmed period value into a periodic digital pulse train, so rpm measurement paths can be driven in loopback and in simulation. Period convention: a programmed value N gives rising edges spaced exactly N+1 clock cycles apart. A period-measuring counter that clears on each rising edge and increments once per cycle therefore captures N. New periods load through a strobe and take effect only at period boundaries, so no pulse is ever truncated.

Parameters:
RPM_WIDTH, 32, width of period values and of the internal cycle counter
HIGH_CYCLES, 4, nominal pulse high time in clock cycles (must be >= 1)
COUNT_WIDTH, 16, width of the emitted-pulse counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
enable  input  1  run request; level-sensitive
period_in  input  RPM_WIDTH  requested period N (edge spacing N+1 cycles)
period_load  input  1  single-cycle strobe; captures period_in into the pending register
pulse  output  1  generated pulse train, registered
period_cur  output  RPM_WIDTH  period N in force for the current pulse cycle
pulse_count  output  COUNT_WIDTH  number of rising edges emitted, wraps modulo 2^COUNT_WIDTH
running  output  1  high while the FSM is in HIGH or LOW

Behaviour:
- Reset: synchronous active-high, applied the same edge it is sampled, overrides all other inputs.
- Outputs after reset: pulse=0, period_cur=0, pulse_count=0, running=0.
- Internal state after reset: pending register=0, cycle counter cnt=0, FSM in IDLE.
- Pending register: loaded from period_in on each cycle period_load=1. The latest load wins. A load has no effect on the current cycle.
- Effective period at a boundary: if period_load=1 in that cycle, period_in (bypass); otherwise the pending register.
- High length: H = min(HIGH_CYCLES, N). This guarantees at least one low cycle per period.
- FSM IDLE:
  - pulse=0, running=0.
  - Leaves IDLE when enable=1 and effective period >= 1. On that edge: period_cur <= effective period, cnt <= 0, state <= HIGH.
  - Result: pulse is 1 in the cycle after enable is sampled high (latency 1 cycle).
  - Effective period 0 keeps the FSM in IDLE.
- FSM HIGH:
  - pulse=1, cnt increments every cycle.
  - When cnt == H-1: go to LOW and set pulse=0.
- FSM LOW:
  - pulse=0, cnt increments every cycle.
  - When cnt == period_cur (the boundary cycle):
    - if enable=1 and effective period >= 1: period_cur <= effective period, cnt <= 0, state <= HIGH, so pulse rises on the next cycle;
    - otherwise: state <= IDLE, cnt <= 0. period_cur holds its last value.
- Rising-edge spacing = period_cur+1 cycles; high time H cycles; low time period_cur+1-H cycles.
- pulse_count: increments on every transition into HIGH. Wraps from all-ones to 0 with no flag.
- enable deasserted mid-period: the current high and low phases complete unchanged. Stop occurs at the boundary, never mid-pulse.
- enable reasserted before that boundary: the generator continues seamlessly with no gap.
- Reset during HIGH or LOW: pulse=0 and all outputs cleared on the next cycle. The pending period is lost.
- cnt is RPM_WIDTH wide, so it cannot overflow, because cnt <= period_cur is always true.
- Maximum N = 2^RPM_WIDTH - 1; edge spacing is computed internally without overflow.

Test Plan:
1. Basic run: rst, then period_load with period_in=9, then enable=1 (HIGH_CYCLES=4) -> pulse rises the cycle after enable; subsequent rises every 10 cycles; high 4 cycles, low 6; pulse_count 1,2,3...; running=1; period_cur=9.
2. Period change: running at N=9, period_load with period_in=4 three cycles after a rise -> that period still spans 10 cycles; every later period spans 5 cycles (high 4, low 1); period_cur changes to 4 exactly at the rise.
3. Clamp and bypass: period_load with period_in=2 asserted in the boundary cycle -> the new period applies immediately; high 2, low 1, spacing 3.
4. Stop and zero period: enable=0 during HIGH at N=9 -> the full 10-cycle period completes, then pulse stays 0, running=0, pulse_count frozen. Separately, enable=1 with pending 0 -> FSM stays IDLE and pulse stays 0.
5. Reset mid-pulse: rst=1 during HIGH -> next cycle pulse=0, pulse_count=0, period_cur=0, running=0. With enable still 1 and no reload, the FSM stays IDLE.
6. Counter wrap: COUNT_WIDTH=4, N=2, run 17 pulses -> pulse_count sequence ...14,15,0,1.
